adc_sample_replayer: RTL and testbench

Self-contained capture-and-replay engine for the oscilloscope bring-up path. A synthetic ramp ADC is sampled into an internal 256-byte sample RAM. The stored samples are then streamed back over the UART transmitter on host request. It sits behind the top-level state watcher as one `activate`/`done` slave and shares the UART RX/TX signals with the other command handlers.

---
 rtl/adc_replay_pkg.sv | 22 ++
 rtl/adc_sample_replayer_sample_ram.sv | 32 +++
 rtl/adc_sample_replayer.sv | 160 ++++++++++++++++
 tb/tb_adc_sample_replayer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_replay_pkg.sv
// Shared types and constants for the ADC capture-and-replay engine.
//   state_e        : replay FSM states
//   DEF_*_WIDTH    : default sample/UART width and RAM address width
//   CMD_COUNT_ALL  : count byte that requests the whole RAM depth
package adc_replay_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 8;

  // A requested byte count of zero decodes to the full RAM depth.
  localparam logic [DEF_DATA_WIDTH-1:0] CMD_COUNT_ALL = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WAIT_CMD,
    ST_SEND,
    ST_WAIT_TX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/adc_sample_replayer_sample_ram.sv
// Sample store: synchronous write, asynchronous read, no reset.
//   clk      : clock
//   we       : write enable
//   addr_in  : write address
//   data_in  : write data
//   addr_out : read address
//   data_out : read data (combinational)
module sample_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr_in] <= data_in;
    end
  end

  assign data_out = mem[addr_out];

endmodule

// File: rtl/adc_sample_replayer.sv
// Capture a synthetic ramp ADC into a sample RAM, then replay N bytes over
// the UART transmitter on host request.
//   clk, reset : clock, synchronous active-high reset
//   activate   : session enable level; low aborts to IDLE
//   done       : session finished, held until activate falls
//   rx_ready   : received-byte strobe; rx_data carries the count (0 = all)
//   tx_data    : byte to transmit, held from tx_start until the next request
//   tx_start   : one-cycle transmit request
//   tx_active  : transmitter busy
//   tx_done    : one-cycle transmit-complete strobe
module adc_sample_replayer
  import adc_replay_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned SAMPLE_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  activate,
  output logic                  done,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_active,
  input  logic                  tx_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [DATA_WIDTH-1:0] adc_q, adc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  done_q, done_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic                  strobe_c;
  logic                  ram_we_c;
  logic [DATA_WIDTH-1:0] ram_rdata_c;

  // Free-running sample divider and ramp; untouched by session start.
  always_comb begin
    strobe_c = (div_q == DIV_W'(SAMPLE_DIV - 1));
    div_d    = strobe_c ? '0 : div_q + DIV_W'(1);
    adc_d    = strobe_c ? adc_q + DATA_WIDTH'(1) : adc_q;
  end

  // Next-state and registered-output logic; activate low overrides everything.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    done_d     = done_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    ram_we_c   = 1'b0;

    if (!activate) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!done_q) begin
            state_d = ST_CAPTURE;
            addr_d  = '0;
          end
        end
        ST_CAPTURE: begin
          if (strobe_c) begin
            ram_we_c = 1'b1;
            addr_d   = addr_q + ADDR_WIDTH'(1);
            if (addr_q == LAST_ADDR) begin
              state_d = ST_WAIT_CMD;
            end
          end
        end
        ST_WAIT_CMD: begin
          if (rx_ready) begin
            count_d = (rx_data == DATA_WIDTH'(CMD_COUNT_ALL)) ? CNT_W'(DEPTH)
                                                              : CNT_W'(rx_data);
            addr_d  = '0;
            state_d = ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_active) begin
            tx_data_d  = ram_rdata_c;
            tx_start_d = 1'b1;
            state_d    = ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          if (tx_done) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            // addr_q counts bytes already sent; this completion is byte addr_q+1.
            if (CNT_W'(addr_q) + CNT_W'(1) == count_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_SEND;
            end
          end
        end
        ST_DONE: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      adc_q      <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      adc_q      <= adc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  sample_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sample_ram (
    .clk     (clk),
    .we      (ram_we_c),
    .addr_in (addr_q),
    .data_in (adc_q),
    .addr_out(addr_q),
    .data_out(ram_rdata_c)
  );

  assign done     = done_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_adc_sample_replayer.sv
// Bench for adc_sample_replayer: ramp/RAM model, transmitter model, and a
// negedge compare process checking done, tx_start and tx_data every cycle.
module tb_adc_sample_replayer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       activate = 1'b0;
  logic       done;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;

  always #5 clk = ~clk;

  adc_sample_replayer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .SAMPLE_DIV(D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .activate (activate),
    .done     (done),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_active(tx_active),
    .tx_done  (tx_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter: busy the cycle after tx_start, tx_done 10 cycles after tx_start.
  bit hold_busy = 1'b0;
  bit xmit_busy = 1'b0;
  bit xmit_pend = 1'b0;
  int xmit_cnt  = 0;

  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (xmit_pend) begin
      xmit_pend = 1'b0;
      xmit_busy = 1'b1;
      xmit_cnt  = 9;
    end else if (xmit_busy) begin
      xmit_cnt--;
      if (xmit_cnt == 0) begin
        xmit_busy = 1'b0;
        tx_done   = 1'b1;
      end
    end
    if (tx_start === 1'b1) xmit_pend = 1'b1;
    tx_active = xmit_busy | hold_busy;
  end

  // Model state: cycle index since reset release, ramp-derived RAM image,
  // the outstanding command and the expected done level.
  int         ncyc;
  bit         prev_act, prev_txa, prev_txs;
  bit         exp_done, armed, in_flight;
  int         n_cmd, tx_idx, done_cnt;
  int         start_cnt = 0;
  logic [7:0] ram_m [256];
  logic [7:0] held;
  logic [7:0] sent_q [$];

  always @(negedge clk) begin
    if (reset) begin
      ncyc = 0; prev_act = 0; prev_txa = 0; prev_txs = 0;
      exp_done = 0; armed = 0; in_flight = 0;
    end else begin
      check(done === exp_done, "done_level", int'(done), int'(exp_done));

      // Rising activate: capture begins next cycle; the first write lands on
      // the first strobe cycle (c % D == D-1) and stores the ramp value c / D.
      if (activate && !prev_act) begin
        int c0;
        c0 = ncyc + 1;
        while (c0 % D != D - 1) c0++;
        for (int i = 0; i < 256; i++) ram_m[i] = 8'((c0 / D) + i);
      end

      if (rx_ready) begin
        n_cmd    = (rx_data == 8'h00) ? 256 : int'(rx_data);
        tx_idx   = 0;
        done_cnt = 0;
        armed    = 1;
        sent_q.delete();
      end

      if (tx_start === 1'b1) begin
        start_cnt++;
        check(!prev_txs, "tx_start_width", 1, 0);
        check(!prev_txa, "tx_start_while_busy", 1, 0);
        check(armed && tx_idx < n_cmd, "tx_start_allowed", tx_idx, n_cmd);
        if (tx_idx < 256)
          check(tx_data === ram_m[tx_idx], "tx_byte", int'(tx_data), int'(ram_m[tx_idx]));
        sent_q.push_back(tx_data);
        tx_idx++;
        held      = tx_data;
        in_flight = 1;
      end else if (in_flight) begin
        check(tx_data === held, "tx_data_hold", int'(tx_data), int'(held));
      end

      if (in_flight && tx_done) begin
        in_flight = 0;
        done_cnt++;
        if (done_cnt == n_cmd) begin
          armed = 0;
          if (activate) exp_done = 1;
        end
      end

      if (!activate) begin
        exp_done  = 0;
        armed     = 0;
        in_flight = 0;
      end

      prev_act = activate;
      prev_txa = tx_active;
      prev_txs = (tx_start === 1'b1);
      ncyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] n);
    rx_data  = n;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    for (int i = 0; i < limit && done !== 1'b1; i++) tick();
    check(done === 1'b1, name, int'(done), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int s0;
    int s1;

    // Reset held two cycles with activate already high.
    reset = 1'b1;
    activate = 1'b1;
    tick();
    tick();
    check(done === 1'b0, "reset_done", int'(done), 0);
    check(tx_start === 1'b0, "reset_tx_start", int'(tx_start), 0);
    check(tx_data === 8'h00, "reset_tx_data", int'(tx_data), 0);
    reset = 1'b0;

    // Session 1: capture from reset, replay 3 bytes.
    repeat (1100) tick();
    send_cmd(8'h03);
    wait_done(200, "done_after_n3");
    check(sent_q.size() == 3, "n3_count", sent_q.size(), 3);
    check(sent_q[0] == 8'h00, "n3_byte0", int'(sent_q[0]), 0);
    check(sent_q[1] == 8'h01, "n3_byte1", int'(sent_q[1]), 1);
    check(sent_q[2] == 8'h02, "n3_byte2", int'(sent_q[2]), 2);

    // Session 2: fresh capture with a continuing ramp, replay all 256.
    activate = 1'b0;
    tick();
    tick();
    check(done === 1'b0, "done_cleared", int'(done), 0);
    activate = 1'b1;
    repeat (1100) tick();
    send_cmd(8'h00);
    wait_done(4000, "done_after_n256");
    check(sent_q.size() == 256, "n256_count", sent_q.size(), 256);
    check(sent_q[255] == 8'(sent_q[0] + 8'd255), "n256_last",
          int'(sent_q[255]), int'(8'(sent_q[0] + 8'd255)));

    // Session 3: busy transmitter, then abort mid-SEND.
    activate = 1'b0;
    tick();
    tick();
    activate = 1'b1;
    repeat (1100) tick();
    hold_busy = 1'b1;
    tick();
    s0 = start_cnt;
    send_cmd(8'h03);
    repeat (20) tick();
    check(start_cnt == s0, "busy_no_start", start_cnt, s0);
    hold_busy = 1'b0;
    for (int i = 0; i < 6 && start_cnt == s0; i++) tick();
    repeat (3) tick();
    check(start_cnt == s0 + 1, "busy_one_pulse", start_cnt, s0 + 1);
    hold_busy = 1'b1;
    for (int i = 0; i < 30 && done_cnt < 1; i++) tick();
    check(done_cnt == 1, "first_tx_done", done_cnt, 1);
    repeat (5) tick();
    activate = 1'b0;
    s1 = start_cnt;
    repeat (30) tick();
    check(start_cnt == s1, "abort_no_start", start_cnt, s1);
    check(done === 1'b0, "abort_done_low", int'(done), 0);
    hold_busy = 1'b0;
    repeat (7) tick();

    // Restart after abort: ramp continues, one byte replayed.
    activate = 1'b1;
    repeat (1100) tick();
    send_cmd(8'h01);
    wait_done(100, "done_after_restart");
    check(sent_q.size() == 1, "restart_count", sent_q.size(), 1);

    activate = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
